// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
// Holds the main-decoder opcode constants, the fetch state encoding,
// the default reset PC and small helpers for redirect target arithmetic.
// No ports; imported by fetch_unit and next_pc_calc.
package cpu_pkg;

  // Opcode field values seen by the main control decoder (ifid_instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BEN   = 6'b000110;
  localparam logic [5:0] OP_BVF   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // FETCH_REQ       : request driven to instruction memory
  // FETCH_WAIT_DROP : request outstanding whose answer belongs to a squashed path
  // FETCH_HOLD      : word captured while IF/ID was stalled
  typedef enum logic [1:0] {
    FETCH_REQ       = 2'd0,
    FETCH_WAIT_DROP = 2'd1,
    FETCH_HOLD      = 2'd2
  } fetch_state_t;

  // Word-scaled immediate added to PC+4; wraps modulo 2^32
  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [31:0] imm);
    return pc4 + {imm[29:0], 2'b00};
  endfunction

  // Region-relative jump: keep the top nibble of PC+4
  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] jidx);
    return {pc4[31:28], jidx, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Redirect resolution for the instruction currently in EX.
// Ports:
//   branch/ben/bvf/jump : control bits of the EX instruction
//   zero/neg/ovf        : ALU flags of the EX instruction
//   pc4, imm, jidx      : PC+4, sign-extended immediate, jump index
//   take                : a redirect must be taken this cycle
//   target              : new PC when take is set
// Purely combinational.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic        branch,
  input  logic        ben,
  input  logic        bvf,
  input  logic        jump,
  input  logic        zero,
  input  logic        neg,
  input  logic        ovf,
  input  logic [31:0] pc4,
  input  logic [31:0] imm,
  input  logic [25:0] jidx,
  output logic        take,
  output logic [31:0] target
);

  // Each conditional branch pairs with exactly one ALU flag; jumps always go
  always_comb begin
    take = (branch & zero) | (ben & neg) | (bvf & ovf) | jump;
  end

  // A jump overrides any branch target that may be decoded alongside it
  always_comb begin
    target = branch_target(pc4, imm);
    if (jump) begin
      target = jump_target(pc4, jidx);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// Holds the PC, fetches one word at a time over a req/ack handshake with
// instruction memory, and fills the IF/ID register. Redirects from EX
// (beq/ben/bvf/j) flush IF/ID and restart fetching at the target; a fetch
// already in flight when the redirect hits is waited out and its data dropped.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   imem_req/addr          : fetch request and word address (held until ack)
//   imem_ack/rdata         : fetch response
//   stall                  : downstream cannot accept, hold IF/ID
//   ex_*                   : control bits, flags and operands of the EX instruction
//   ifid_valid/instr/pc4   : IF/ID register
//   redirect               : registered one-cycle pulse after a taken redirect
// Optional feature: define FETCH_PERF_CNT_EN to add the perf_fetched and
// perf_flushed counters and their output ports.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        ex_branch,
  input  logic        ex_ben,
  input  logic        ex_bvf,
  input  logic        ex_jump,
  input  logic        ex_zero,
  input  logic        ex_neg,
  input  logic        ex_ovf,
  input  logic [31:0] ex_pc4,
  input  logic [31:0] ex_imm,
  input  logic [25:0] ex_jidx,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        redirect
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  held_word;
  logic         req_q;
  logic         take;
  logic [31:0]  target;
  logic         load_ifid;
  logic [31:0]  load_word;

  next_pc_calc u_next_pc (
    .branch (ex_branch),
    .ben    (ex_ben),
    .bvf    (ex_bvf),
    .jump   (ex_jump),
    .zero   (ex_zero),
    .neg    (ex_neg),
    .ovf    (ex_ovf),
    .pc4    (ex_pc4),
    .imm    (ex_imm),
    .jidx   (ex_jidx),
    .take   (take),
    .target (target)
  );

  assign imem_req  = req_q;
  assign imem_addr = pc;

  // IF/ID advances either straight from memory or from the held word once
  // the stall clears; a redirect in the same cycle squashes either source.
  always_comb begin
    load_ifid = 1'b0;
    load_word = imem_rdata;
    if (!take && !stall) begin
      if (state == FETCH_REQ && imem_ack) begin
        load_ifid = 1'b1;
      end else if (state == FETCH_HOLD) begin
        load_ifid = 1'b1;
        load_word = held_word;
      end
    end
  end

  // Fetch FSM with registered request and IF/ID outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH_REQ;
      req_q      <= 1'b1;
      pc         <= RESET_PC;
      held_word  <= '0;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc4   <= '0;
      redirect   <= 1'b0;
    end else begin
      redirect <= take;
      if (take) begin
        pc         <= target;
        ifid_valid <= 1'b0;
        // The memory still owes an answer for an unacked request; that
        // answer belongs to the squashed path and must be swallowed.
        if ((state == FETCH_REQ || state == FETCH_WAIT_DROP) && !imem_ack) begin
          state <= FETCH_WAIT_DROP;
          req_q <= 1'b0;
        end else begin
          state <= FETCH_REQ;
          req_q <= 1'b1;
        end
      end else if (load_ifid) begin
        ifid_valid <= 1'b1;
        ifid_instr <= load_word;
        ifid_pc4   <= pc + 32'd4;
        pc         <= pc + 32'd4;
        state      <= FETCH_REQ;
        req_q      <= 1'b1;
      end else begin
        case (state)
          FETCH_REQ: begin
            if (imem_ack) begin
              held_word <= imem_rdata;
              state     <= FETCH_HOLD;
              req_q     <= 1'b0;
            end else if (!stall) begin
              ifid_valid <= 1'b0;
            end
          end
          FETCH_WAIT_DROP: begin
            if (imem_ack) begin
              state <= FETCH_REQ;
              req_q <= 1'b1;
            end
            if (!stall) begin
              ifid_valid <= 1'b0;
            end
          end
          default: begin
            state <= FETCH_HOLD;
          end
        endcase
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Event counters: IF/ID loads, and redirects that killed a live IF/ID entry
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (load_ifid) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (take && ifid_valid) begin
        perf_flushed <= perf_flushed + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run compared
// cycle by cycle against a behavioural fetch model kept in this file.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        ex_branch, ex_ben, ex_bvf, ex_jump;
  logic        ex_zero, ex_neg, ex_ovf;
  logic [31:0] ex_pc4, ex_imm;
  logic [25:0] ex_jidx;
  logic        ifid_valid;
  logic [31:0] ifid_instr, ifid_pc4;
  logic        redirect;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  int errors = 0;
  int checks = 0;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .ex_branch  (ex_branch),
    .ex_ben     (ex_ben),
    .ex_bvf     (ex_bvf),
    .ex_jump    (ex_jump),
    .ex_zero    (ex_zero),
    .ex_neg     (ex_neg),
    .ex_ovf     (ex_ovf),
    .ex_pc4     (ex_pc4),
    .ex_imm     (ex_imm),
    .ex_jidx    (ex_jidx),
    .ifid_valid (ifid_valid),
    .ifid_instr (ifid_instr),
    .ifid_pc4   (ifid_pc4),
    .redirect   (redirect)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  // Memory: fast mode acks every request cycle after the first (words equal
  // their address); slow mode latches one address and answers slow_lat cycles later.
  logic        slow_mode = 1'b0;
  int          slow_lat  = 3;
  logic        req_q;
  logic        s_out, s_ack;
  int          s_cnt;
  logic [31:0] s_addr, s_data;

  always @(posedge clk) begin
    if (reset) begin
      req_q  <= 1'b0;
      s_out  <= 1'b0;
      s_ack  <= 1'b0;
      s_cnt  <= 0;
      s_addr <= '0;
      s_data <= '0;
    end else begin
      req_q <= imem_req;
      s_ack <= 1'b0;
      if (s_out) begin
        if (s_cnt <= 1) begin
          s_ack  <= 1'b1;
          s_data <= s_addr;
          s_out  <= 1'b0;
        end else begin
          s_cnt <= s_cnt - 1;
        end
      end else if (imem_req && !s_ack) begin
        s_out  <= 1'b1;
        s_addr <= imem_addr;
        s_cnt  <= slow_lat - 1;
      end
    end
  end

  assign imem_ack   = slow_mode ? s_ack  : (imem_req && req_q);
  assign imem_rdata = slow_mode ? s_data : imem_addr;

  // Reference model: what the fetch stage should hold, in terms of "pc",
  // "a word is waiting to enter IF/ID", "a squashed fetch is still in flight".
  logic [31:0] m_pc, m_buf, m_instr, m_pc4;
  bit          m_drop, m_have_buf, m_valid, m_redirect;
  int unsigned m_fetched, m_flushed;

  function automatic bit m_req();
    return !(m_drop || m_have_buf);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_buf = 0; m_instr = 0; m_pc4 = 0;
    m_drop = 0; m_have_buf = 0; m_valid = 0; m_redirect = 0;
    m_fetched = 0; m_flushed = 0;
  endtask

  task automatic model_advance();
    bit          t;
    bit          asking;
    logic [31:0] tgt;
    t = (ex_branch && ex_zero) || (ex_ben && ex_neg) || (ex_bvf && ex_ovf) || ex_jump;
    if (ex_jump) tgt = {ex_pc4[31:28], ex_jidx, 2'b00};
    else         tgt = ex_pc4 + ex_imm * 32'd4;
    asking = m_req() || m_drop;
    if (t && m_valid) m_flushed++;
    m_redirect = t;
    if (t) begin
      m_drop = asking && !imem_ack;
      m_have_buf = 0;
      m_valid = 0;
      m_pc = tgt;
    end else if (m_drop) begin
      if (imem_ack) m_drop = 0;
      if (!stall) m_valid = 0;
    end else if (m_have_buf) begin
      if (!stall) begin
        m_valid = 1; m_instr = m_buf; m_pc4 = m_pc + 4; m_pc = m_pc + 4;
        m_have_buf = 0; m_fetched++;
      end
    end else if (imem_ack) begin
      if (!stall) begin
        m_valid = 1; m_instr = imem_rdata; m_pc4 = m_pc + 4; m_pc = m_pc + 4;
        m_fetched++;
      end else begin
        m_buf = imem_rdata; m_have_buf = 1;
      end
    end else if (!stall) begin
      m_valid = 0;
    end
  endtask

  // One clock: model consumes the inputs set at the falling edge, then the
  // DUT clocks; returns at the next falling edge with outputs settled.
  task automatic tick();
    #1;
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_ex();
    ex_branch = 0; ex_ben = 0; ex_bvf = 0; ex_jump = 0;
    ex_zero = 0; ex_neg = 0; ex_ovf = 0;
    ex_pc4 = 0; ex_imm = 0; ex_jidx = 0;
  endtask

  task automatic do_reset(input logic slow);
    @(negedge clk);
    slow_mode = slow;
    reset = 1; stall = 0;
    clear_ex();
    repeat (3) @(negedge clk);
    reset = 0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL reset_req got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got %h expected 0", imem_addr); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", ifid_valid); end
    checks++; if (ifid_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr got %h expected 0", ifid_instr); end
    checks++; if (ifid_pc4 !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc4 got %h expected 0", ifid_pc4); end
    checks++; if (redirect !== 1'b0) begin errors++; $display("[TB] FAIL reset_redirect got %b expected 0", redirect); end
  endtask

  // Zero-wait stream: cycle k after release shows address 4*(k-1), and
  // from cycle 2 on IF/ID carries word 4*(k-2) with PC+4 of 4*(k-1).
  task automatic test_sequential();
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++; if (imem_addr !== 32'(4 * (k - 1))) begin errors++; $display("[TB] FAIL seq_addr k=%0d got %h expected %h", k, imem_addr, 4 * (k - 1)); end
      if (k == 1) begin
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_valid_early got %b expected 0", ifid_valid); end
      end else begin
        checks++; if (ifid_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid k=%0d got %b expected 1", k, ifid_valid); end
        checks++; if (ifid_instr !== 32'(4 * (k - 2))) begin errors++; $display("[TB] FAIL seq_instr k=%0d got %h expected %h", k, ifid_instr, 4 * (k - 2)); end
        checks++; if (ifid_pc4 !== 32'(4 * (k - 1))) begin errors++; $display("[TB] FAIL seq_pc4 k=%0d got %h expected %h", k, ifid_pc4, 4 * (k - 1)); end
      end
    end
  endtask

  task automatic test_branch();
    ex_branch = 1; ex_zero = 1; ex_pc4 = 32'h20; ex_imm = -32'sd2;
    tick();
    clear_ex();
    checks++; if (imem_addr !== 32'h18) begin errors++; $display("[TB] FAIL beq_addr got %h expected 18", imem_addr); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL beq_flush got %b expected 0", ifid_valid); end
    checks++; if (redirect !== 1'b1) begin errors++; $display("[TB] FAIL beq_redirect got %b expected 1", redirect); end
    tick();
    checks++; if (redirect !== 1'b0) begin errors++; $display("[TB] FAIL beq_pulse got %b expected 0", redirect); end
    checks++; if (ifid_instr !== 32'h18 || ifid_valid !== 1'b1) begin errors++; $display("[TB] FAIL beq_target_word got %h/%b expected 18/1", ifid_instr, ifid_valid); end
    checks++; if (ifid_pc4 !== 32'h1C) begin errors++; $display("[TB] FAIL beq_target_pc4 got %h expected 1c", ifid_pc4); end
    ex_branch = 1; ex_zero = 0; ex_pc4 = 32'h20; ex_imm = -32'sd2;
    tick();
    clear_ex();
    checks++; if (redirect !== 1'b0) begin errors++; $display("[TB] FAIL beq_nt_redirect got %b expected 0", redirect); end
    checks++; if (imem_addr !== 32'h20 || ifid_instr !== 32'h1C) begin errors++; $display("[TB] FAIL beq_nt_flow got %h/%h expected 20/1c", imem_addr, ifid_instr); end
  endtask

  task automatic test_ben_bvf();
    ex_ben = 1; ex_neg = 1; ex_pc4 = 32'h100; ex_imm = 32'd4;
    tick(); clear_ex();
    checks++; if (imem_addr !== 32'h110 || redirect !== 1'b1) begin errors++; $display("[TB] FAIL ben_taken got %h/%b expected 110/1", imem_addr, redirect); end
    tick();
    ex_bvf = 1; ex_ovf = 1; ex_pc4 = 32'h200; ex_imm = 32'd1;
    tick(); clear_ex();
    checks++; if (imem_addr !== 32'h204 || redirect !== 1'b1) begin errors++; $display("[TB] FAIL bvf_taken got %h/%b expected 204/1", imem_addr, redirect); end
    tick();
    ex_ben = 1; ex_ovf = 1; ex_pc4 = 32'h300; ex_imm = 32'd8;
    tick(); clear_ex();
    checks++; if (redirect !== 1'b0 || imem_addr !== 32'h20C) begin errors++; $display("[TB] FAIL ben_wrong_flag got %b/%h expected 0/20c", redirect, imem_addr); end
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h208) begin errors++; $display("[TB] FAIL ben_wrong_flag_ifid got %b/%h expected 1/208", ifid_valid, ifid_instr); end
  endtask

  task automatic test_jump();
    ex_jump = 1; ex_branch = 1; ex_zero = 1; ex_imm = 32'd5;
    ex_pc4 = 32'hF000_0010; ex_jidx = 26'h40;
    tick(); clear_ex();
    checks++; if (imem_addr !== 32'hF000_0100 || redirect !== 1'b1) begin errors++; $display("[TB] FAIL jump_addr got %h/%b expected f0000100/1", imem_addr, redirect); end
    tick();
    checks++; if (ifid_instr !== 32'hF000_0100 || ifid_pc4 !== 32'hF000_0104) begin errors++; $display("[TB] FAIL jump_ifid got %h/%h expected f0000100/f0000104", ifid_instr, ifid_pc4); end
  endtask

  // Redirect while the slow memory still owes an answer for address 0.
  task automatic test_redirect_drop();
    bit seen;
    do_reset(1'b1);
    tick();
    ex_branch = 1; ex_zero = 1; ex_pc4 = 32'h40; ex_imm = 32'd4;
    tick(); clear_ex();
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h50 || redirect !== 1'b1) begin errors++; $display("[TB] FAIL drop_enter got req=%b addr=%h redir=%b expected 0/50/1", imem_req, imem_addr, redirect); end
    seen = 0;
    for (int c = 0; c < 15 && !seen; c++) begin
      tick();
      if (ifid_valid) begin
        seen = 1;
        checks++; if (ifid_instr !== 32'h50 || ifid_pc4 !== 32'h54) begin errors++; $display("[TB] FAIL drop_first_word got %h/%h expected 50/54", ifid_instr, ifid_pc4); end
      end
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL drop_timeout got no valid word expected target word 50"); end
  endtask

  task automatic test_stall();
    logic [31:0] snap_instr, snap_pc4, w;
    bit seen;
    do_reset(1'b0);
    repeat (4) tick();
    snap_instr = ifid_instr; snap_pc4 = ifid_pc4; w = imem_addr;
    stall = 1;
    tick();
    for (int c = 0; c < 4; c++) begin
      if (c == 3) stall = 0;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL hold_req c=%0d got %b expected 0", c, imem_req); end
      checks++; if (ifid_instr !== snap_instr || ifid_pc4 !== snap_pc4 || ifid_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_ifid c=%0d got %h/%h expected %h/%h", c, ifid_instr, ifid_pc4, snap_instr, snap_pc4); end
      tick();
    end
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== w || ifid_pc4 !== w + 4) begin errors++; $display("[TB] FAIL hold_release got %b/%h/%h expected 1/%h/%h", ifid_valid, ifid_instr, ifid_pc4, w, w + 4); end
    seen = 0;
    for (int c = 0; c < 5 && !seen; c++) begin
      tick();
      if (ifid_valid) begin
        seen = 1;
        checks++; if (ifid_instr !== w + 4) begin errors++; $display("[TB] FAIL hold_next_word got %h expected %h", ifid_instr, w + 4); end
      end
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL hold_next_timeout got none expected %h", w + 4); end
  endtask

  task automatic test_random();
    do_reset(1'b0);
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      clear_ex();
      if (!(imem_req && !imem_ack) && $urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: ex_branch = 1;
          1: ex_ben = 1;
          2: ex_bvf = 1;
          default: ex_jump = 1;
        endcase
        ex_zero = 1'($urandom); ex_neg = 1'($urandom); ex_ovf = 1'($urandom);
        ex_pc4 = $urandom; ex_imm = $urandom; ex_jidx = 26'($urandom);
      end
      tick();
      checks++; if (imem_req !== m_req()) begin errors++; $display("[TB] FAIL rand_req c=%0d got %b expected %b", c, imem_req, m_req()); end
      checks++; if (imem_addr !== m_pc) begin errors++; $display("[TB] FAIL rand_addr c=%0d got %h expected %h", c, imem_addr, m_pc); end
      checks++; if (ifid_valid !== m_valid) begin errors++; $display("[TB] FAIL rand_valid c=%0d got %b expected %b", c, ifid_valid, m_valid); end
      checks++; if (ifid_instr !== m_instr || ifid_pc4 !== m_pc4) begin errors++; $display("[TB] FAIL rand_ifid c=%0d got %h/%h expected %h/%h", c, ifid_instr, ifid_pc4, m_instr, m_pc4); end
      checks++; if (redirect !== m_redirect) begin errors++; $display("[TB] FAIL rand_redirect c=%0d got %b expected %b", c, redirect, m_redirect); end
    end
    clear_ex(); stall = 0;
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_fetched !== m_fetched) begin errors++; $display("[TB] FAIL perf_fetched got %0d expected %0d", perf_fetched, m_fetched); end
    checks++; if (perf_flushed !== m_flushed) begin errors++; $display("[TB] FAIL perf_flushed got %0d expected %0d", perf_flushed, m_flushed); end
`endif
  endtask

  initial begin
    reset = 1; stall = 0;
    clear_ex();
    model_reset();
    test_reset();
    test_sequential();
    test_branch();
    test_ben_bvf();
    test_jump();
    test_redirect_drop();
    test_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
